twiddle_rom_pack_writer: RTL
============================

Name: twiddle_rom_pack_writer

Overview:
- Write-side counterpart of the ROM read-path decomposition.
- Accepts a serial stream of D_width twiddle values over a valid/ready handshake and packs each group of 16 into eight doulbe_D_width bank words.
- Bank order is b0b1, b2b3, …, b14b15; the even lane goes in the upper half and the odd lane in the lower half.
- Issues one common-address write per 16-value row to the eight ROM/RAM banks; sits between the twiddle preload loader and the DTFAG bank memories.

Parameters:
- D_W, `D_width (64): width of one twiddle value.
- ROWS, 4096: number of bank rows to fill (65536 / 16).
- ADDR_W, $clog2(ROWS): bank address width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- start  input  1  single-cycle pulse; begins a fill from row 0
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  D_W  twiddle value; lane = arrival order mod 16
- wr_en  output  1  write strobe, common to all eight banks
- wr_addr  output  ADDR_W  row address, common to all banks
- ROM_b0b1_D … ROM_b14b15_D  output  2*D_W each (8 ports)  packed bank write data
- busy  output  1  high from the cycle after an accepted start until the cycle before done
- done  output  1  single-cycle pulse after the last row write

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, all ROM_bXbY_D=0, busy=0, done=0, lane=0, row=0, state=IDLE.
- All outputs are registered.
- Handshake: a value transfers on a cycle where in_valid & in_ready.
  - in_valid with in_ready=0 is ignored; there is no buffering outside FILL.
  - in_data is not required to hold once in_ready is low.
- Packing rule: lane k (0..15) goes to bank word i=k>>1.
  - k even: bits [2*D_W-1:D_W].
  - k odd: bits [D_W-1:0].
  - This is the exact inverse of the read-side split.
- IDLE:
  - in_ready=0.
  - start → FILL with row=0, lane=0, busy=1.
- FILL:
  - in_ready=1.
  - Each transfer writes the lane slot and increments lane.
  - A transfer at lane 15 → WRITE, and lane wraps to 0.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_addr=row, all eight data ports hold the complete row.
  - in_ready=0.
  - If row==ROWS-1 → DONE; else row+1 and → FILL.
  - Latency: wr_en rises the cycle after the 16th transfer.
  - Throughput: 16 values per 17 cycles.
- DONE (1 cycle):
  - done=1, busy=0, in_ready=0 → IDLE.
  - wr_addr and data ports hold their last values.
- Outside WRITE, wr_en=0. Data ports may change as slots fill; consumers sample only on wr_en.
- Boundary conditions:
  - start while not IDLE: ignored, with no restart or row reset.
  - start coincident with DONE: ignored. A new fill needs start in IDLE.
  - Rows wrap never: the fill terminates at ROWS-1 and wr_addr never exceeds ROWS-1.
  - Reset mid-fill: immediate return to reset values; the partial row is discarded and no write is issued.
  - in_valid held high across WRITE: no transfer occurs in the WRITE cycle; the next value is lane 0 of the next row, accepted in the first FILL cycle.

Decomposition:
- Shared package:
  - LANES=16, BANKS=8.
  - State enum {IDLE, FILL, WRITE, DONE}.
  - Lane-to-bank/half mapping function (bank=k>>1, upper=~k[0]); the read-side split reuses this function so the two stay consistent.
- D_width and doulbe_D_width stay in define.svh.
- One natural sub-module, twiddle_row_packer:
  - 16-slot lane register file.
  - Input load enable + lane index; output of eight packed double words.
  - The top level keeps the FSM, counters and handshake.

Test Plan:
- Single row, ROWS=4 build: start, then feed values 0x0..0xF back-to-back.
  - One wr_en pulse with wr_addr=0, the cycle after the 16th transfer.
  - ROM_b0b1_D={0x0,0x1}, ROM_b14b15_D={0xE,0xF}.
  - Then in_ready=1 the following cycle.
- Full fill, ROWS=4: feed 64 values, value = index.
  - Four wr_en pulses at addrs 0,1,2,3, each 17 cycles apart.
  - Row 3 b6b7={0x36,0x37}.
  - done pulses once, then in_ready=0 and busy=0.
- Backpressure/gaps: randomly deassert in_valid during a row.
  - Packed words match the no-gap case; wr_en only after 16 transfers.
  - No transfer during the WRITE cycle, even with in_valid=1.
- Reset mid-row: assert rst_n=0 after 7 transfers in row 2.
  - All outputs return to 0 asynchronously, with no wr_en.
  - After start, row 0 is rewritten from lane 0.
- Spurious start: pulse start during FILL and during DONE.
  - The row counter is unaffected; no restart.
  - A start in IDLE afterwards begins a fresh fill at wr_addr=0.
- Loopback: drive the packed ports into the read-side decomposition logic.
  - ROM_bk_out equals lane k for all k=0..15 over random data.

Source files
------------

// File: rtl/twiddle_rom_pack_writer_pkg.sv
// Shared definitions for the twiddle ROM pack writer and its read-side
// counterpart.
// Contents:
//   LANES, BANKS   - twiddle values per row and bank words per row
//   LANE_W, BANK_W - index widths for lanes and banks
//   state_t        - writer FSM states
//   lane_bank()    - bank word that holds lane k (k >> 1)
//   lane_upper()   - 1 when lane k sits in the upper half of its bank word
// The read-side split calls the same two functions, so packing and
// unpacking always agree.
package twiddle_rom_pack_writer_pkg;

   localparam int LANES  = 16;
   localparam int BANKS  = 8;
   localparam int LANE_W = 4;
   localparam int BANK_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_t;

   // Even/odd lane pairs share one bank word.
   function automatic logic [BANK_W-1:0] lane_bank(input logic [LANE_W-1:0] k);
      return k[LANE_W-1:1];
   endfunction

   // Even lanes go in the upper half of the bank word.
   function automatic logic lane_upper(input logic [LANE_W-1:0] k);
      return ~k[0];
   endfunction

endpackage

// File: rtl/twiddle_rom_pack_writer_row_packer.sv
// twiddle_row_packer: holds one row of sixteen twiddle values and presents
// them as eight packed double-width bank words.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load_en     - write load_data into the slot chosen by load_lane
//   load_lane   - lane index, 0..15
//   load_data   - twiddle value to store
//   bank_words  - eight packed words. Word i is {lane 2i, lane 2i+1}.
module twiddle_row_packer
   import twiddle_rom_pack_writer_pkg::*;
#(
   parameter int D_W = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_en,
   input  logic [LANE_W-1:0]             load_lane,
   input  logic [D_W-1:0]                load_data,
   output logic [BANKS-1:0][2*D_W-1:0]   bank_words
);

   logic [LANES-1:0][D_W-1:0] slots;

   // The lane register file is cleared on reset. This discards any partial
   // row, and the data ports read back as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots <= '0;
      end else if (load_en) begin
         slots[load_lane] <= load_data;
      end
   end

   // This block only routes each slot to its bank-word half; it adds no
   // logic. The shared mapping functions choose the route, so the read-side
   // split uses exactly the same arrangement.
   always_comb begin
      bank_words = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_upper(LANE_W'(k))) begin
            bank_words[lane_bank(LANE_W'(k))][D_W +: D_W] = slots[k];
         end else begin
            bank_words[lane_bank(LANE_W'(k))][0 +: D_W] = slots[k];
         end
      end
   end

endmodule

// File: rtl/twiddle_rom_pack_writer.sv
// twiddle_rom_pack_writer: takes a serial valid/ready stream of twiddle
// values. It packs each group of sixteen values into eight double-width
// bank words, then issues one common-address write per row to the eight
// DTFAG bank memories.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   start               - one-cycle pulse; starts a fill from row 0 (IDLE only)
//   in_valid, in_ready  - handshake; a value transfers when both are high
//   in_data             - twiddle value; its lane is the arrival order mod 16
//   wr_en, wr_addr      - one-cycle write strobe and row address, shared by all banks
//   ROM_bXbY_D          - packed bank write data, {even lane, odd lane}
//   busy                - a fill is in progress
//   done                - one-cycle pulse after the last row write
module twiddle_rom_pack_writer
   import twiddle_rom_pack_writer_pkg::*;
#(
   parameter int D_W    = 64,
   parameter int ROWS   = 4096,
   parameter int ADDR_W = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [D_W-1:0]    in_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [2*D_W-1:0]  ROM_b0b1_D,
   output logic [2*D_W-1:0]  ROM_b2b3_D,
   output logic [2*D_W-1:0]  ROM_b4b5_D,
   output logic [2*D_W-1:0]  ROM_b6b7_D,
   output logic [2*D_W-1:0]  ROM_b8b9_D,
   output logic [2*D_W-1:0]  ROM_b10b11_D,
   output logic [2*D_W-1:0]  ROM_b12b13_D,
   output logic [2*D_W-1:0]  ROM_b14b15_D,
   output logic              busy,
   output logic              done
);

   state_t              state_q, state_n;
   logic [LANE_W-1:0]   lane_q, lane_n;
   logic [ADDR_W-1:0]   row_q, row_n;
   logic                in_ready_n, wr_en_n, busy_n, done_n;
   logic [ADDR_W-1:0]   wr_addr_n;
   logic                transfer;
   logic [BANKS-1:0][2*D_W-1:0] bank_words;

   // in_ready is a registered copy of "state is FILL", so a transfer can
   // only be accepted in FILL. This also blocks transfers in the WRITE cycle.
   assign transfer = in_valid & in_ready;

   twiddle_row_packer #(
      .D_W(D_W)
   ) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (transfer),
      .load_lane  (lane_q),
      .load_data  (in_data),
      .bank_words (bank_words)
   );

   assign ROM_b0b1_D   = bank_words[0];
   assign ROM_b2b3_D   = bank_words[1];
   assign ROM_b4b5_D   = bank_words[2];
   assign ROM_b6b7_D   = bank_words[3];
   assign ROM_b8b9_D   = bank_words[4];
   assign ROM_b10b11_D = bank_words[5];
   assign ROM_b12b13_D = bank_words[6];
   assign ROM_b14b15_D = bank_words[7];

   // Next-state logic, followed by the registered outputs. The outputs
   // are decoded from the next state, so each one is valid in the same
   // cycle as its state. Start is honoured only in IDLE. The row counter
   // stops at ROWS-1 and never wraps.
   always_comb begin
      state_n = state_q;
      lane_n  = lane_q;
      row_n   = row_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = FILL;
               lane_n  = '0;
               row_n   = '0;
            end
         end
         FILL: begin
            if (transfer) begin
               lane_n = lane_q + LANE_W'(1);
               if (lane_q == LANE_W'(LANES - 1)) begin
                  state_n = WRITE;
               end
            end
         end
         WRITE: begin
            if (row_q == ADDR_W'(ROWS - 1)) begin
               state_n = DONE;
            end else begin
               row_n   = row_q + ADDR_W'(1);
               state_n = FILL;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      in_ready_n = (state_n == FILL);
      wr_en_n    = (state_n == WRITE);
      busy_n     = (state_n == FILL) || (state_n == WRITE);
      done_n     = (state_n == DONE);
      wr_addr_n  = (state_n == WRITE) ? row_q : wr_addr;
   end

   // State, counters and registered outputs. All of them return to zero
   // or IDLE as soon as reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lane_q   <= '0;
         row_q    <= '0;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_n;
         lane_q   <= lane_n;
         row_q    <= row_n;
         in_ready <= in_ready_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule
